// File: rtl/fir_tap_feeder_if.sv
// Sample stream handshake into the FIR tap feeder.
interface fir_tap_feeder_if #(parameter int DW = 4);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/fir_tap_feeder.sv
// 10-deep tap delay line feeding the coefficient/sum stage, with window-full
// pulse and a y_valid that lines up with the downstream registered sum.
module fir_tap_feeder #(
  parameter int DW       = 4,
  parameter int PIPE_LAT = 2
) (
  input  logic               clk,
  input  logic               reset,
  fir_tap_feeder_if.slave    s,
  input  logic               flush,
  output logic [DW-1:0]      x_0,
  output logic [DW-1:0]      x_1,
  output logic [DW-1:0]      x_2,
  output logic [DW-1:0]      x_3,
  output logic [DW-1:0]      x_4,
  output logic [DW-1:0]      x_5,
  output logic [DW-1:0]      x_6,
  output logic [DW-1:0]      x_7,
  output logic [DW-1:0]      x_8,
  output logic [DW-1:0]      x_9,
  output logic               taps_valid,
  output logic               y_valid,
  output logic [3:0]         fill_cnt
);
  localparam int TAPS = 10;
  localparam int CW   = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  state_t                   state, state_nxt;
  logic [CW-1:0]            drain, drain_nxt;
  logic [3:0]               fill_nxt;
  logic                     tv_nxt;
  logic                     accept;
  logic [TAPS-1:0][DW-1:0]  x;
  logic [PIPE_LAT-1:0]      vld_pipe;

  assign s.s_ready = !reset && !flush && (state != FLUSH);
  assign accept    = s.s_valid && s.s_ready;

  always_comb begin
    state_nxt = state;
    drain_nxt = drain;
    fill_nxt  = fill_cnt;
    tv_nxt    = accept && ((state == RUN) || (state == FILL && fill_cnt == 4'd9));
    if (flush) begin
      state_nxt = FLUSH;
      drain_nxt = CW'(PIPE_LAT);
      fill_nxt  = '0;
    end else begin
      case (state)
        FILL: if (accept) begin
          fill_nxt = fill_cnt + 4'd1;
          if (fill_cnt == 4'd9) state_nxt = RUN;
        end
        RUN: fill_nxt = 4'd10;
        // leave on the edge where the count reaches zero: PIPE_LAT cycles in FLUSH
        FLUSH: begin
          if (drain <= CW'(1)) begin
            state_nxt = FILL;
            drain_nxt = '0;
          end else begin
            drain_nxt = drain - CW'(1);
          end
        end
        default: state_nxt = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FILL;
      drain      <= '0;
      fill_cnt   <= '0;
      taps_valid <= 1'b0;
      x          <= '0;
    end else begin
      state      <= state_nxt;
      drain      <= drain_nxt;
      fill_cnt   <= fill_nxt;
      taps_valid <= tv_nxt;
      if (flush)       x <= '0;
      else if (accept) x <= {x[TAPS-2:0], s.s_data};
    end
  end

  // keeps shifting through FLUSH so in-flight results still emerge
  generate
    if (PIPE_LAT == 1) begin : g_pipe1
      always_ff @(posedge clk or posedge reset)
        if (reset) vld_pipe <= '0;
        else       vld_pipe <= taps_valid;
    end else begin : g_pipen
      always_ff @(posedge clk or posedge reset)
        if (reset) vld_pipe <= '0;
        else       vld_pipe <= {vld_pipe[PIPE_LAT-2:0], taps_valid};
    end
  endgenerate

  assign y_valid = vld_pipe[PIPE_LAT-1];

  assign x_0 = x[0];
  assign x_1 = x[1];
  assign x_2 = x[2];
  assign x_3 = x[3];
  assign x_4 = x[4];
  assign x_5 = x[5];
  assign x_6 = x[6];
  assign x_7 = x[7];
  assign x_8 = x[8];
  assign x_9 = x[9];
endmodule

// File: tb/tb_fir_tap_feeder.sv
// Scoreboard bench for fir_tap_feeder: expected windows and y_valid cycles are
// queued as samples are driven and checked when the DUT pulses.
module tb_fir_tap_feeder;
  localparam int DW = 4;
  localparam int PL = 2;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic [DW-1:0] x_0, x_1, x_2, x_3, x_4, x_5, x_6, x_7, x_8, x_9;
  logic taps_valid, y_valid;
  logic [3:0] fill_cnt;
  logic [9:0][DW-1:0] got;

  fir_tap_feeder_if #(.DW(DW)) bus ();

  fir_tap_feeder #(.DW(DW), .PIPE_LAT(PL)) dut (
    .clk(clk), .reset(reset), .s(bus), .flush(flush),
    .x_0(x_0), .x_1(x_1), .x_2(x_2), .x_3(x_3), .x_4(x_4),
    .x_5(x_5), .x_6(x_6), .x_7(x_7), .x_8(x_8), .x_9(x_9),
    .taps_valid(taps_valid), .y_valid(y_valid), .fill_cnt(fill_cnt)
  );

  always #5 clk = ~clk;

  assign got = {x_9, x_8, x_7, x_6, x_5, x_4, x_3, x_2, x_1, x_0};

  typedef struct {
    int                 cyc;
    logic [9:0][DW-1:0] w;
  } exp_t;

  exp_t               tq[$];
  int                 yq[$];
  exp_t               e;
  logic [9:0][DW-1:0] mw;
  int                 m_fill, m_fl;
  int                 cyc = 0;
  int                 n_cmp = 0, n_err = 0;

  always @(posedge clk) cyc = cyc + 1;

  // output monitor: sampled on the falling edge
  always @(negedge clk) begin
    if (tq.size() > 0 && tq[0].cyc < cyc) begin
      n_cmp++; n_err++;
      $display("FAIL taps_missed: taps_valid=0 at cycle %0d, required 1", tq[0].cyc);
      void'(tq.pop_front());
    end
    if (taps_valid) begin
      n_cmp++;
      if (tq.size() == 0 || tq[0].cyc != cyc) begin
        n_err++;
        $display("FAIL taps_unexpected: taps_valid=1 at cycle %0d, required 0", cyc);
      end else begin
        e = tq.pop_front();
        n_cmp++;
        if (got !== e.w || fill_cnt !== 4'd10) begin
          n_err++;
          $display("FAIL taps_window: got x9..x0=%h fill=%0d, required %h fill=10",
                   got, fill_cnt, e.w);
        end
      end
    end
    if (yq.size() > 0 && yq[0] < cyc) begin
      n_cmp++; n_err++;
      $display("FAIL y_missed: y_valid=0 at cycle %0d, required 1", yq[0]);
      void'(yq.pop_front());
    end
    if (y_valid) begin
      n_cmp++;
      if (yq.size() == 0 || yq[0] != cyc) begin
        n_err++;
        $display("FAIL y_unexpected: y_valid=1 at cycle %0d, required 0", cyc);
      end else begin
        void'(yq.pop_front());
      end
    end
  end

  task automatic model_clear();
    mw = '0; m_fill = 0; m_fl = 0;
    tq.delete(); yq.delete();
  endtask

  // drive one cycle starting 1 time unit after a rising edge; model updated here
  task automatic step(input logic v, input logic [DW-1:0] d, input logic f);
    bit acc;
    exp_t n;
    bus.s_valid = v; bus.s_data = d; flush = f;
    acc = v && !f && (m_fl == 0);
    if (acc) begin
      mw = {mw[8:0], d};
      if (m_fill < 10) m_fill++;
      if (m_fill == 10) begin
        n.cyc = cyc + 1; n.w = mw;
        tq.push_back(n);
        yq.push_back(cyc + 1 + PL);
      end
    end
    if (f) begin
      mw = '0; m_fill = 0; m_fl = PL;
    end else if (m_fl > 0) begin
      m_fl--;
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
    model_clear();
    #2;
    n_cmp++;
    if (got !== '0 || taps_valid !== 1'b0 || y_valid !== 1'b0 ||
        fill_cnt !== 4'd0 || bus.s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: x=%h tv=%b yv=%b fill=%0d rdy=%b, required all 0",
               got, taps_valid, y_valid, fill_cnt, bus.s_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_reset: s_ready=%b, required 1", bus.s_ready);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, DW'(i), 1'b0);
      if (i == 9) begin
        n_cmp++;
        if (fill_cnt !== 4'd9 || taps_valid !== 1'b0) begin
          n_err++;
          $display("FAIL fill_partial: fill=%0d tv=%b, required 9 0", fill_cnt, taps_valid);
        end
      end
    end
    idle(4);
  endtask

  task automatic test_back_to_back();
    step(1'b1, 4'd11, 1'b0);
    step(1'b1, 4'd12, 1'b0);
    idle(4);
  endtask

  task automatic test_gap();
    step(1'b1, 4'd5, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 4'hF, 1'b0);
      n_cmp++;
      if (x_0 !== 4'd5 || x_1 !== 4'd12) begin
        n_err++;
        $display("FAIL gap_hold: x_0=%0d x_1=%0d, required 5 12", x_0, x_1);
      end
    end
    step(1'b1, 4'd6, 1'b0);
    idle(4);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) step(1'b1, DW'(i + 1), 1'b0);
    flush = 1'b1; bus.s_valid = 1'b1;
    #1;
    n_cmp++;
    if (bus.s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL flush_ready0: s_ready=%b, required 0", bus.s_ready);
    end
    step(1'b1, 4'hA, 1'b1);
    n_cmp++;
    if (bus.s_ready !== 1'b0 || got !== '0 || fill_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL flush_cleared: rdy=%b x=%h fill=%0d, required 0 0 0",
               bus.s_ready, got, fill_cnt);
    end
    step(1'b1, 4'hB, 1'b0);
    n_cmp++;
    if (bus.s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL flush_ready2: s_ready=%b, required 0", bus.s_ready);
    end
    step(1'b1, 4'hC, 1'b0);
    n_cmp++;
    if (bus.s_ready !== 1'b1 || fill_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL flush_exit: rdy=%b fill=%0d, required 1 0", bus.s_ready, fill_cnt);
    end
    for (int i = 0; i < 10; i++) step(1'b1, DW'(15 - i), 1'b0);
    idle(4);
  endtask

  task automatic test_flush_after_accept();
    step(1'b1, 4'd7, 1'b0);
    step(1'b1, 4'd8, 1'b1);
    n_cmp++;
    if (got !== '0 || fill_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL flush_b_dropped: x=%h fill=%0d, required 0 0", got, fill_cnt);
    end
    idle(5);
    n_cmp++;
    if (fill_cnt !== 4'd0 || x_0 !== 4'd0) begin
      n_err++;
      $display("FAIL flush_after_idle: fill=%0d x_0=%0d, required 0 0", fill_cnt, x_0);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) step(1'b1, DW'(i + 3), 1'b0);
    #1;
    reset = 1'b1;
    model_clear();
    #1;
    n_cmp++;
    if (got !== '0 || taps_valid !== 1'b0 || y_valid !== 1'b0 ||
        fill_cnt !== 4'd0 || bus.s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: x=%h tv=%b yv=%b fill=%0d rdy=%b, required all 0",
               got, taps_valid, y_valid, fill_cnt, bus.s_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    idle(5);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_gap();
    test_flush();
    test_flush_after_accept();
    test_reset_mid();
    idle(3);
    n_cmp++;
    if (tq.size() != 0 || yq.size() != 0) begin
      n_err++;
      $display("FAIL pending_left: taps=%0d y=%0d outstanding, required 0 0",
               tq.size(), yq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end
endmodule
